// File: rtl/enable_gen_pkg.sv
// Shared types for the enable generator.
// Holds the FSM state type and the raw encodings behind it.
package enable_gen_pkg;

  localparam logic [1:0] StateIdleEnc = 2'b00;
  localparam logic [1:0] StateRunEnc  = 2'b01;
  localparam logic [1:0] StateStepEnc = 2'b10;

  typedef enum logic [1:0] {
    StIdle = StateIdleEnc,
    StRun  = StateRunEnc,
    StStep = StateStepEnc
  } state_e;

endpackage

// File: rtl/enable_gen_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, optional debounce filter, rising-edge detector.
// Build option: define ENABLE_GEN_DEBOUNCE_EN to include the debounce filter; without it
// the synchronizer output feeds the edge detector directly.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high; clears all state to 0
//   btn   - raw asynchronous button level, high = pressed
//   press - one-cycle pulse on each 0->1 transition of the conditioned level
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef ENABLE_GEN_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Level follows the synchronized input only after it has disagreed for
  // DEB_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
`else
  // Keeps DEB_CYCLES referenced when the filter is compiled out.
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign level      = sync2_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign press = level & ~prev_q;

endmodule

// File: rtl/enable_gen.sv
// Enable generator: run/stop and single-step buttons drive an IDLE/RUN/STEP FSM that emits
// single-cycle count-enable pulses for a downstream counter.
// Build option: define ENABLE_GEN_DEBOUNCE_EN to include the button debounce filters.
// Ports:
//   clock     - rising-edge clock
//   reset     - synchronous, active-high
//   btn_run   - raw run/stop button, high = pressed
//   btn_step  - raw single-step button, high = pressed
//   div_value - enable period minus 1 (quasi-static)
//   enable    - registered single-cycle count-enable pulse
//   running   - high while the FSM is in RUN
module enable_gen
  import enable_gen_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic [DIV_W-1:0] div_value,
  output logic             enable,
  output logic             running
);

  logic run_press, step_press;

  btn_conditioner #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_run_cond (
    .clock(clock),
    .reset(reset),
    .btn  (btn_run),
    .press(run_press)
  );

  btn_conditioner #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_cond (
    .clock(clock),
    .reset(reset),
    .btn  (btn_step),
    .press(step_press)
  );

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             enable_q, enable_d;

  always_comb begin
    state_d  = state_q;
    div_d    = '0;
    enable_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_press) begin
          state_d = StRun;
        end else if (step_press) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (run_press) begin
          state_d = StIdle;
        end
      end
      StStep:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The divider restarts from 0 on entry to RUN and after every pulse. The pulse is
    // computed one cycle ahead so the output is a flop; a lowered div_value therefore
    // fires on the next cycle instead of wrapping.
    if (state_q == StRun && state_d == StRun) begin
      div_d = enable_q ? '0 : div_q + DIV_W'(1);
    end
    enable_d = (state_d == StStep) || (state_d == StRun && div_d >= div_value);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      div_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      enable_q <= enable_d;
    end
  end

  assign enable  = enable_q;
  assign running = (state_q == StRun);

endmodule

// File: tb/tb_enable_gen.sv
// Directed bench for enable_gen with a per-cycle scoreboard of expected running/enable.
module tb_enable_gen;

  localparam int DivW = 16;
  localparam int Deb  = 4;
`ifdef ENABLE_GEN_DEBOUNCE_EN
  localparam int Lat = 3 + Deb;
`else
  localparam int Lat = 3;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic            btn_run;
  logic            btn_step;
  logic [DivW-1:0] div_value;
  logic            enable;
  logic            running;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string tag;
    logic  run_e;
    logic  en_e;
  } exp_t;

  exp_t sbq[$];

  enable_gen #(
    .DIV_W     (DivW),
    .DEB_CYCLES(Deb)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .div_value(div_value),
    .enable   (enable),
    .running  (running)
  );

  always #5 clock = ~clock;

  task automatic push(input string tag, input logic r, input logic e);
    exp_t x;
    x.tag   = tag;
    x.run_e = r;
    x.en_e  = e;
    sbq.push_back(x);
  endtask

  // One clock; outputs sampled 1 time unit after the edge against the oldest expectation.
  task automatic tick();
    exp_t x;
    @(posedge clock);
    #1;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      total += 2;
      assert (running === x.run_e) else begin
        bad++;
        $error("FAIL %s running got=%b want=%b t=%0t", x.tag, running, x.run_e, $time);
      end
      assert (enable === x.en_e) else begin
        bad++;
        $error("FAIL %s enable got=%b want=%b t=%0t", x.tag, enable, x.en_e, $time);
      end
    end
  endtask

  // Drives n cycles of button pattern and expects running in [on, off) (on=0: never,
  // off=0: to the end), enable every dv+1 running cycles at phase ph, plus a step pulse
  // at tick stp.
  task automatic win(input string tag, input int n, input int r1a, input int r1b,
                     input int r2a, input int r2b, input int s_a, input int s_b,
                     input int on, input int off, input int ph, input int dv, input int stp);
    logic r, e;
    for (int t = 1; t <= n; t++) begin
      btn_run  = (t >= r1a && t <= r1b) || (t >= r2a && t <= r2b);
      btn_step = (t >= s_a && t <= s_b);
      r = (on > 0) && (t >= on) && (off == 0 || t < off);
      e = (r && ((t - on + ph) % (dv + 1) == dv)) || (t == stp);
      push(tag, r, e);
      tick();
    end
    btn_run  = 1'b0;
    btn_step = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_run   = 1'b0;
    btn_step  = 1'b0;
    div_value = DivW'(3);

    push("reset", 1'b0, 1'b0);
    tick();
    push("reset", 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Run for a while at period 4, then stop with a second press.
    win("run_stop", 40 + Lat, 1, 10, 21, 30, 0, 0, Lat, 20 + Lat, 0, 3, 0);

    // Held step button: exactly one pulse, never running.
    win("step", 30, 0, 0, 0, 0, 1, 20, 0, 0, 0, 3, Lat);

    // Both pressed together in IDLE: RUN wins; abort by reset with divider at 2.
    win("both", Lat + 2, 1, Lat + 2, 0, 0, 1, Lat + 2, Lat, 0, 0, 3, 0);
    reset = 1'b1;
    push("rst_in_run", 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    push("after_rst", 1'b0, 1'b0);
    tick();

    // Divisor 9, lowered to 2 while divider is 7, then 0, then stop.
    div_value = DivW'(9);
    win("dv9", Lat + 7, 1, 6, 0, 0, 0, 0, Lat, 0, 0, 9, 0);
    div_value = DivW'(2);
    win("dv2", 9, 0, 0, 0, 0, 0, 0, 1, 0, 2, 2, 0);
    div_value = DivW'(0);
    win("dv0", 6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    win("stop0", Lat + 10, 1, 8, 0, 0, 0, 0, 1, Lat, 0, 0, 0);

    // Button held through reset release still needs a qualified edge.
    div_value = DivW'(3);
    btn_run   = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("hold_in_rst", 1'b0, 1'b0);
      tick();
    end
    reset = 1'b0;
    win("hold_rst", Lat + 4, 1, Lat + 4, 0, 0, 0, 0, Lat, 0, 0, 3, 0);
    reset = 1'b1;
    push("rst2", 1'b0, 1'b0);
    tick();
    reset = 1'b0;

`ifdef ENABLE_GEN_DEBOUNCE_EN
    // Short glitches are filtered out.
    for (int t = 1; t <= 20; t++) begin
      btn_run = (t <= 12) && (((t - 1) % 4) < 2);
      push("glitch", 1'b0, 1'b0);
      tick();
    end
    btn_run = 1'b0;
`else
    // Without the filter a 2-cycle pulse is a real press.
    win("glitch", 8, 1, 2, 0, 0, 0, 0, 3, 0, 0, 3, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
